// File: rtl/mem_responder.sv
// mem_responder
//   Responder end of the memory request interface. Owns a DEPTH x DATA_WIDTH storage array
//   and serves write and read requests from an initiator over a valid/ready handshake.
//   A write commits in the cycle it is accepted and returns a one-cycle done or error pulse.
//   A read is latched, read synchronously from the array, and presented on a held response
//   channel with backpressure.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-high
//   req_valid  in   initiator presents a request
//   req_ready  out  responder accepts a request this cycle (IDLE only)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   request address
//   req_wdata  in   write data
//   wr_done    out  one-cycle pulse: in-range write committed
//   wr_err     out  one-cycle pulse: write rejected as out of range
//   rsp_valid  out  read response available
//   rsp_ready  in   initiator accepts the read response
//   rsp_data   out  read data, held while rsp_valid
//   rsp_err    out  read was out of range, qualified by rsp_valid
//   wr_count   out  accepted in-range writes, saturating
//   rd_count   out  accepted in-range reads, saturating

module mem_responder #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  wr_done,
   output logic                  wr_err,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [CNT_WIDTH-1:0]  wr_count,
   output logic [CNT_WIDTH-1:0]  rd_count
);

   localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and every address compares below.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      StIdle,
      StRdAccess,
      StResp
   } state_e;

   state_e state_q, state_d;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [IDX_WIDTH-1:0]  rd_idx_q;
   logic                  rd_oor_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_err_q;
   logic                  wr_done_q;
   logic                  wr_err_q;
   logic [CNT_WIDTH-1:0]  wr_cnt_q;
   logic [CNT_WIDTH-1:0]  rd_cnt_q;

   logic                  req_in_range;
   logic [IDX_WIDTH-1:0]  req_idx;
   logic                  wr_fire;
   logic                  rd_fire;

   assign req_in_range = {1'b0, req_addr} < DEPTH_LIM;
   assign req_idx      = req_addr[IDX_WIDTH-1:0];
   assign wr_fire      = req_valid && req_ready && req_we;
   assign rd_fire      = req_valid && req_ready && !req_we;

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            if (req_valid && !req_we) begin
               state_d = StRdAccess;
            end
         end
         StRdAccess: begin
            state_d = StResp;
         end
         StResp: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Control, response and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         rd_idx_q   <= '0;
         rd_oor_q   <= 1'b0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         wr_err_q   <= 1'b0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_done_q <= wr_fire && req_in_range;
         wr_err_q  <= wr_fire && !req_in_range;

         if (rd_fire) begin
            rd_idx_q <= req_idx;
            rd_oor_q <= !req_in_range;
         end

         // Array read happens one cycle after acceptance, so a write committed on the
         // accepting edge (or earlier) is always visible here.
         if (state_q == StRdAccess) begin
            rsp_data_q <= rd_oor_q ? '0 : mem_q[rd_idx_q];
            rsp_err_q  <= rd_oor_q;
         end

         if (wr_fire && req_in_range && (wr_cnt_q != CNT_MAX)) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
         end
         if (rd_fire && req_in_range && (rd_cnt_q != CNT_MAX)) begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
         end
      end
   end

   // Storage is never reset; a write on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (!rst && wr_fire && req_in_range) begin
         mem_q[req_idx] <= req_wdata;
      end
   end

   assign wr_done  = wr_done_q;
   assign wr_err   = wr_err_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;
   assign wr_count = wr_cnt_q;
   assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Self-checking bench for mem_responder. Main instance uses DEPTH=200 so the address
//   boundary is exercised; a second instance uses DEPTH=256 with 3-bit counters to show
//   saturation and the no-error full address range.

module tb_mem_responder;

   localparam int TB_DEPTH = 200;

   logic tb_clock = 1'b0;
   always #5 tb_clock = ~tb_clock;

   // Main instance
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [7:0]  req_wdata;
   logic        wr_done;
   logic        wr_err;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   // Saturation instance
   logic        s_rst;
   logic        s_req_valid;
   logic        s_req_ready;
   logic        s_req_we;
   logic [7:0]  s_req_addr;
   logic [7:0]  s_req_wdata;
   logic        s_wr_done;
   logic        s_wr_err;
   logic        s_rsp_valid;
   logic        s_rsp_ready;
   logic [7:0]  s_rsp_data;
   logic        s_rsp_err;
   logic [2:0]  s_wr_count;
   logic [2:0]  s_rd_count;

   mem_responder #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (8),
      .DEPTH      (TB_DEPTH),
      .CNT_WIDTH  (16)
   ) dut (
      .clk       (tb_clock),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .wr_done   (wr_done),
      .wr_err    (wr_err),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .wr_count  (wr_count),
      .rd_count  (rd_count)
   );

   mem_responder #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (8),
      .DEPTH      (256),
      .CNT_WIDTH  (3)
   ) dut_sat (
      .clk       (tb_clock),
      .rst       (s_rst),
      .req_valid (s_req_valid),
      .req_ready (s_req_ready),
      .req_we    (s_req_we),
      .req_addr  (s_req_addr),
      .req_wdata (s_req_wdata),
      .wr_done   (s_wr_done),
      .wr_err    (s_wr_err),
      .rsp_valid (s_rsp_valid),
      .rsp_ready (s_rsp_ready),
      .rsp_data  (s_rsp_data),
      .rsp_err   (s_rsp_err),
      .wr_count  (s_wr_count),
      .rd_count  (s_rd_count)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: plain word array plus unbounded operation counts.
   logic [7:0] model_mem [0:255];
   logic [7:0] s_model_mem [0:255];
   int         exp_wr = 0;
   int         exp_rd = 0;

   function automatic logic [15:0] sat16(input int n);
      return (n > 65535) ? 16'hFFFF : 16'(n);
   endfunction

   function automatic logic [2:0] sat3(input int n);
      return (n > 7) ? 3'd7 : 3'(n);
   endfunction

   task automatic tick();
      @(posedge tb_clock);
      #1;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
      logic ok;
      ok = (int'(addr) < TB_DEPTH);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL wr_pre_ready addr=%0d got=%b want=1", addr, req_ready);
      end
      req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
      tick();
      if (ok) begin
         model_mem[addr] = data;
         exp_wr++;
      end
      total++;
      if (wr_done !== ok) begin
         bad++; $display("FAIL wr_done addr=%0d got=%b want=%b", addr, wr_done, ok);
      end
      total++;
      if (wr_err !== !ok) begin
         bad++; $display("FAIL wr_err addr=%0d got=%b want=%b", addr, wr_err, !ok);
      end
      total++;
      if (wr_count !== sat16(exp_wr)) begin
         bad++; $display("FAIL wr_count got=%0d want=%0d", wr_count, sat16(exp_wr));
      end
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL wr_post_ready addr=%0d got=%b want=1", addr, req_ready);
      end
      req_valid = 1'b0;
   endtask

   // stall = cycles rsp_ready is held low once the response is valid.
   // noise drives ignored requests while the responder is busy.
   task automatic do_read(input logic [7:0] addr, input int stall, input bit noise);
      logic       ok;
      logic [7:0] exp_data;
      ok       = (int'(addr) < TB_DEPTH);
      exp_data = ok ? model_mem[addr] : 8'h00;
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL rd_pre_ready addr=%0d got=%b want=1", addr, req_ready);
      end
      req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
      rsp_ready = 1'($urandom);
      tick();
      if (ok) exp_rd++;
      total++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         bad++; $display("FAIL rd_access addr=%0d ready=%b valid=%b want 0/0",
                         addr, req_ready, rsp_valid);
      end
      total++;
      if (rd_count !== sat16(exp_rd)) begin
         bad++; $display("FAIL rd_count got=%0d want=%0d", rd_count, sat16(exp_rd));
      end
      if (noise) begin
         req_valid = 1'b1; req_we = 1'($urandom);
         req_addr = 8'($urandom); req_wdata = 8'($urandom);
      end else begin
         req_valid = 1'b0;
      end
      rsp_ready = 1'($urandom);
      tick();
      for (int k = 0; k <= stall; k++) begin
         total++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            bad++; $display("FAIL rd_resp_hs addr=%0d cyc=%0d valid=%b ready=%b want 1/0",
                            addr, k, rsp_valid, req_ready);
         end
         total++;
         if (rsp_data !== exp_data || rsp_err !== !ok) begin
            bad++; $display("FAIL rd_resp_data addr=%0d cyc=%0d data=%h err=%b want %h/%b",
                            addr, k, rsp_data, rsp_err, exp_data, !ok);
         end
         total++;
         if (wr_done !== 1'b0 || wr_err !== 1'b0) begin
            bad++; $display("FAIL rd_busy_write addr=%0d done=%b err=%b want 0/0",
                            addr, wr_done, wr_err);
         end
         rsp_ready = (k == stall);
         if (k < stall || k == stall) tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL rd_return addr=%0d valid=%b ready=%b want 0/1",
                         addr, rsp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd0; req_wdata = 8'hFF;
      tick(); tick();
      rst = 1'b0; req_valid = 1'b0;
      exp_wr = 0; exp_rd = 0;
      total++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_hs ready=%b valid=%b want 1/0", req_ready, rsp_valid);
      end
      total++;
      if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin
         bad++; $display("FAIL reset_rsp data=%h err=%b want 00/0", rsp_data, rsp_err);
      end
      total++;
      if (wr_done !== 1'b0 || wr_err !== 1'b0) begin
         bad++; $display("FAIL reset_pulse done=%b err=%b want 0/0", wr_done, wr_err);
      end
      total++;
      if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
         bad++; $display("FAIL reset_counts wr=%0d rd=%0d want 0/0", wr_count, rd_count);
      end
   endtask

   task automatic test_write_burst();
      for (int i = 0; i < 4; i++) do_write(8'(10 + i), 8'(24 + i));
   endtask

   task automatic test_read_seq();
      for (int i = 0; i < 4; i++) do_read(8'(10 + i), 0, 1'b0);
   endtask

   task automatic test_backpressure();
      do_read(8'd12, 5, 1'b1);
   endtask

   task automatic test_range();
      do_write(8'd200, 8'h55);
      do_read(8'd200, 0, 1'b0);
      do_write(8'd199, 8'hA5);
      do_read(8'd199, 1, 1'b0);
      do_write(8'd255, 8'h12);
      do_read(8'd0, 0, 1'b0);
   endtask

   task automatic test_raw();
      do_write(8'd5, 8'h3C);
      do_read(8'd5, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < TB_DEPTH; i++) do_write(8'(i), 8'($urandom));
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            // Idle cycle with stray rsp_ready must not produce a response.
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            total++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
               bad++; $display("FAIL idle_stray valid=%b ready=%b want 0/1",
                               rsp_valid, req_ready);
            end
         end
         if ($urandom_range(0, 1) == 1)
            do_write(8'($urandom_range(0, 255)), 8'($urandom));
         else
            do_read(8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'($urandom));
      end
   endtask

   task automatic test_reset_mid();
      do_write(8'd13, 8'd27);
      do_write(8'd14, 8'h99);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd13;
      tick();
      req_valid = 1'b0; rsp_ready = 1'b0;
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'd27) begin
         bad++; $display("FAIL mid_resp valid=%b data=%0d want 1/27", rsp_valid, rsp_data);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_wr = 0; exp_rd = 0;
      total++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL mid_reset_hs valid=%b ready=%b want 0/1", rsp_valid, req_ready);
      end
      total++;
      if (wr_count !== 16'd0 || rd_count !== 16'd0) begin
         bad++; $display("FAIL mid_reset_counts wr=%0d rd=%0d want 0/0", wr_count, rd_count);
      end
      do_read(8'd13, 0, 1'b0);
      // Write presented on a reset edge must be dropped.
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd14; req_wdata = 8'h11;
      tick();
      rst = 1'b0; req_valid = 1'b0;
      exp_wr = 0; exp_rd = 0;
      total++;
      if (wr_done !== 1'b0 || wr_count !== 16'd0) begin
         bad++; $display("FAIL rst_write done=%b cnt=%0d want 0/0", wr_done, wr_count);
      end
      do_read(8'd14, 0, 1'b0);
   endtask

   task automatic test_saturation();
      logic [7:0] a;
      s_rst = 1'b1;
      tick();
      s_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a = 8'(255 - i);
         s_req_valid = 1'b1; s_req_we = 1'b1; s_req_addr = a; s_req_wdata = 8'(i * 7 + 1);
         tick();
         s_model_mem[a] = 8'(i * 7 + 1);
         s_req_valid = 1'b0;
         total++;
         if (s_wr_done !== 1'b1 || s_wr_err !== 1'b0) begin
            bad++; $display("FAIL sat_wr_pulse addr=%0d done=%b err=%b want 1/0",
                            a, s_wr_done, s_wr_err);
         end
         total++;
         if (s_wr_count !== sat3(i + 1)) begin
            bad++; $display("FAIL sat_wr_count got=%0d want=%0d", s_wr_count, sat3(i + 1));
         end
      end
      for (int i = 0; i < 9; i++) begin
         a = 8'(255 - (i % 3));
         s_req_valid = 1'b1; s_req_we = 1'b0; s_req_addr = a; s_rsp_ready = 1'b1;
         tick();
         s_req_valid = 1'b0;
         total++;
         if (s_rd_count !== sat3(i + 1)) begin
            bad++; $display("FAIL sat_rd_count got=%0d want=%0d", s_rd_count, sat3(i + 1));
         end
         tick();
         total++;
         if (s_rsp_valid !== 1'b1 || s_rsp_data !== s_model_mem[a] || s_rsp_err !== 1'b0) begin
            bad++; $display("FAIL sat_rd_resp addr=%0d valid=%b data=%h err=%b want 1/%h/0",
                            a, s_rsp_valid, s_rsp_data, s_rsp_err, s_model_mem[a]);
         end
         tick();
         total++;
         if (s_rsp_valid !== 1'b0 || s_req_ready !== 1'b1) begin
            bad++; $display("FAIL sat_rd_return valid=%b ready=%b want 0/1",
                            s_rsp_valid, s_req_ready);
         end
      end
      s_rsp_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;
      s_rst = 1'b1; s_req_valid = 1'b0; s_req_we = 1'b0; s_req_addr = '0; s_req_wdata = '0;
      s_rsp_ready = 1'b0;
      test_reset();
      test_write_burst();
      test_read_seq();
      test_backpressure();
      test_range();
      test_raw();
      test_random();
      test_reset_mid();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
